// File: rtl/sigma_delta_acq_ctrl.sv
// Sigma-delta bitstream acquisition controller: counts ones over decimation
// windows, discards settling windows, and buffers samples in a small FWFT FIFO.
module sigma_delta_acq_ctrl #(
  parameter int DECIM_W    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_WIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [DECIM_W-1:0] cfg_nsamples,
  input  logic               sd_bit,
  output logic               sd_en,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DECIM_W-1:0] m_data,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [3:0]         led
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [DECIM_W-1:0] SETTLE_C = DECIM_W'(SETTLE_WIN);
  localparam logic [DECIM_W-1:0] ONE      = DECIM_W'(1);
  localparam logic [DECIM_W-1:0] TWO      = DECIM_W'(2);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} state_t;
  state_t state;

  logic [DECIM_W-1:0] decim_q, nsamp_q, acc, wcnt, scnt, settle_cnt;
  logic [DECIM_W-1:0] win_val, scnt_nxt;
  logic [DECIM_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               dump, push, push_ok, pop, last_sample;

  assign sd_en       = (state == SETTLE) || (state == RUN);
  assign busy        = (state != IDLE);
  assign dump        = sd_en && (wcnt == decim_q - ONE);
  assign win_val     = acc + DECIM_W'(sd_bit);
  assign m_valid     = (count != '0);
  assign m_data      = m_valid ? mem[rd_ptr] : '0;
  assign pop         = m_valid && m_ready;
  assign push        = (state == RUN) && dump;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push_ok     = push && ((count != DEPTH_C) || pop);
  assign scnt_nxt    = scnt + ONE;
  assign last_sample = push && (nsamp_q != '0) && (scnt_nxt == nsamp_q);
  assign led         = {m_valid, overflow, state == RUN, busy};

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= win_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      decim_q    <= TWO;
      nsamp_q    <= '0;
      acc        <= '0;
      wcnt       <= '0;
      scnt       <= '0;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sd_en) begin
        if (dump) begin
          acc  <= '0;
          wcnt <= '0;
        end else begin
          acc  <= win_val;
          wcnt <= wcnt + ONE;
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      if (push) scnt <= scnt_nxt;
      case (state)
        IDLE: if (cfg_start && !cfg_stop) begin
          decim_q    <= (cfg_decim < TWO) ? TWO : cfg_decim;
          nsamp_q    <= cfg_nsamples;
          overflow   <= 1'b0;
          acc        <= '0;
          wcnt       <= '0;
          scnt       <= '0;
          settle_cnt <= '0;
          state      <= (SETTLE_WIN == 0) ? RUN : SETTLE;
        end
        SETTLE: if (cfg_stop) state <= DRAIN;
          else if (dump) begin
            settle_cnt <= settle_cnt + ONE;
            if (settle_cnt + ONE == SETTLE_C) state <= RUN;
          end
        RUN: if (cfg_stop || last_sample) state <= DRAIN;
        DRAIN: if (count == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sigma_delta_acq_ctrl.md
SIGMA_DELTA_ACQ_CTRL -- requirements
Module: sigma_delta_acq_ctrl

Interface
REQ-001 Parameter DECIM_W, default 16: width of decimation ratio, sample count and output sample.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two: output buffer depth in samples.
REQ-003 Parameter SETTLE_WIN, default 2: number of leading decimation windows discarded after start.
REQ-004 Clock and reset ports: one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cfg_start  in  1  one-cycle start pulse.
REQ-008 cfg_stop  in  1  one-cycle stop pulse.
REQ-009 cfg_decim  in  DECIM_W  oversampling ratio, bitstream cycles per output sample.
REQ-010 cfg_nsamples  in  DECIM_W  samples per acquisition; 0 means continuous.
REQ-011 sd_bit  in  1  modulator bitstream, valid each cycle sd_en=1.
REQ-012 sd_en  out  1  modulator enable.
REQ-013 m_valid / m_ready / m_data  out / in / out DECIM_W  output sample stream.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse on return to IDLE.
REQ-016 overflow  out  1  sticky sample-drop flag.
REQ-017 led  out  4  {fifo non-empty, overflow, state==RUN, busy} (bit 3..0).

Function
REQ-018 FSM states: IDLE, SETTLE, RUN, DRAIN.
REQ-019 IDLE->SETTLE on cfg_start=1 and cfg_stop=0; latch cfg_decim (values 0/1 forced to 2) and cfg_nsamples; clear overflow, accumulator, window counter, sample counter.
REQ-020 cfg_start outside IDLE is ignored; cfg_start and cfg_stop together in IDLE leave state IDLE.
REQ-021 sd_en = 1 in SETTLE and RUN only, combinationally from state.
REQ-022 Each cycle with sd_en=1: window counter +1, accumulator += sd_bit.
REQ-023 Dump cycle: window counter == latched decim-1; window value = accumulator + sd_bit; accumulator and counter reset to 0 same edge.
REQ-024 Window value range 0..decim; always fits DECIM_W bits, no saturation needed.
REQ-025 SETTLE: dumps discarded; after SETTLE_WIN-th dump -> RUN (SETTLE_WIN=0: IDLE->RUN directly).
REQ-026 RUN dump: push window value to FIFO; m_valid high the cycle after the dump edge (latency 1 from dump).
REQ-027 Push when FIFO full succeeds only if a pop (m_valid & m_ready) occurs same cycle; otherwise sample dropped, overflow set, sample still counted.
REQ-028 Sample counter increments per RUN dump; when cfg_nsamples!=0 and count reaches it -> DRAIN on same edge.
REQ-029 cfg_stop in SETTLE or RUN -> DRAIN next edge; partial window discarded; a dump coinciding with cfg_stop is still pushed.
REQ-030 DRAIN: sd_en=0; stays until FIFO empty; then -> IDLE with done=1 for one cycle.
REQ-031 FIFO: FIFO_DEPTH entries, first-word-fall-through, m_data stable while m_valid & !m_ready; pointers wrap modulo FIFO_DEPTH.
REQ-032 cfg_stop in IDLE or DRAIN has no effect.

Reset
REQ-033 rst=1 at any edge: state IDLE, FIFO emptied, counters/accumulator 0, sd_en=0, m_valid=0, m_data=0, busy=0, done=0, overflow=0, led=0; mid-acquisition samples are lost.
REQ-034 rst takes priority over cfg_start, cfg_stop and all pushes/pops in the same cycle.

Verification
REQ-035 decim=8, nsamples=3, sd_bit alternating 1/0, m_ready=1 -> 3 samples of value 4 after 2 discarded windows; done pulse; sd_en high exactly 40 cycles.
REQ-036 decim=4, nsamples=0, sd_bit=1, m_ready=0 -> 4 samples of 4 buffered, 5th dump sets overflow and led[2]; cfg_stop -> DRAIN holds until m_ready=1 empties FIFO, then done.
REQ-037 cfg_decim=1 -> treated as 2; sd_bit=1 gives samples of value 2 every 2 cycles.
REQ-038 cfg_stop asserted on a dump cycle in RUN -> that sample delivered, no further samples, done after drain.
REQ-039 rst asserted mid-RUN with 2 samples buffered -> next cycle m_valid=0, busy=0, led=0; following cfg_start starts a fresh acquisition.
REQ-040 cfg_start with cfg_stop same cycle in IDLE -> busy stays 0; cfg_start during RUN -> no restart, sample counter unchanged.
